// File: rtl/modexp_ctrl.sv
// Square-and-multiply modular exponentiation controller driving an external remainder unit.
// Optional MODEXP_OPCNT_EN adds a 16-bit op_count output counting completed mod operations.
module modexp_ctrl #(
  parameter int BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BITS-1:0]   base,
  input  logic [BITS-1:0]   exponent,
  input  logic [BITS-1:0]   modulus,
  output logic [BITS-1:0]   result,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2*BITS-1:0] mod_dividend,
  output logic [BITS-1:0]   mod_divisor,
  output logic              mod_start,
  input  logic              mod_done,
  input  logic [BITS-1:0]   mod_remainder
`ifdef MODEXP_OPCNT_EN
  ,
  output logic [15:0]       op_count
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, NEXT, FINISH} state_t;
  typedef enum logic [1:0] {OP_RED, OP_MUL, OP_SQR} op_t;

  state_t          state;
  op_t             op;
  logic [BITS-1:0] acc, b, e;
  logic [BITS-1:0] e_sh;
  logic [2*BITS-1:0] prod_mul, prod_sqr;

  assign e_sh     = e >> 1;
  assign prod_mul = {{BITS{1'b0}}, acc} * {{BITS{1'b0}}, b};
  assign prod_sqr = {{BITS{1'b0}}, b} * {{BITS{1'b0}}, b};

  // mod_divisor doubles as the latched modulus register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_RED;
      acc          <= '0;
      b            <= '0;
      e            <= '0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      mod_dividend <= '0;
      mod_divisor  <= '0;
      mod_start    <= 1'b0;
`ifdef MODEXP_OPCNT_EN
      op_count     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          b           <= base;
          e           <= exponent;
          mod_divisor <= modulus;
          acc         <= {{(BITS-1){1'b0}}, 1'b1};
          error       <= 1'b0;
          busy        <= 1'b1;
          op          <= OP_RED;
`ifdef MODEXP_OPCNT_EN
          op_count    <= '0;
`endif
          if (modulus == '0) begin
            acc   <= '0;
            state <= FINISH;
          end else if (exponent == '0) begin
            acc   <= (modulus == {{(BITS-1){1'b0}}, 1'b1}) ? '0 : {{(BITS-1){1'b0}}, 1'b1};
            state <= FINISH;
          end else begin
            state <= REQ;
          end
        end
        REQ: begin
          case (op)
            OP_MUL:  mod_dividend <= prod_mul;
            OP_SQR:  mod_dividend <= prod_sqr;
            default: mod_dividend <= {{BITS{1'b0}}, b};
          endcase
          mod_start <= 1'b1;
          state     <= WAIT;
        end
        WAIT: if (mod_done) begin
          if (op == OP_MUL) acc <= mod_remainder;
          else              b   <= mod_remainder;
          mod_start <= 1'b0;
`ifdef MODEXP_OPCNT_EN
          op_count  <= op_count + 16'd1;
`endif
          state     <= GAP;
        end
        // One forced low cycle lets the responder drop mod_done before the next request.
        GAP: state <= NEXT;
        NEXT: begin
          if (op != OP_MUL && e[0]) begin
            op    <= OP_MUL;
            state <= REQ;
          end else begin
            e <= e_sh;
            if (e_sh != '0) begin
              op    <= OP_SQR;
              state <= REQ;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          error  <= (mod_divisor == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl with a behavioral latency-L remainder responder.
module tb_modexp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base, exponent, modulus;
  logic [31:0] result;
  logic        busy, done, error;
  logic [63:0] mod_dividend;
  logic [31:0] mod_divisor;
  logic        mod_start;
  logic        mod_done;
  logic [31:0] mod_remainder;
`ifdef MODEXP_OPCNT_EN
  logic [15:0] op_count;
`endif

  modexp_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .base(base), .exponent(exponent), .modulus(modulus),
    .result(result), .busy(busy), .done(done), .error(error),
    .mod_dividend(mod_dividend), .mod_divisor(mod_divisor),
    .mod_start(mod_start), .mod_done(mod_done), .mod_remainder(mod_remainder)
`ifdef MODEXP_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Behavioral remainder unit: mod_done rises L edges after mod_start is seen, held until mod_start drops.
  int resp_lat = 3;
  int resp_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_done      <= 1'b0;
      resp_cnt      <= 0;
      mod_remainder <= '0;
    end else if (!mod_start) begin
      mod_done <= 1'b0;
      resp_cnt <= 0;
    end else if (!mod_done) begin
      if (resp_cnt + 1 == resp_lat) begin
        mod_done      <= 1'b1;
        mod_remainder <= 32'(mod_dividend % {32'd0, mod_divisor});
      end else begin
        resp_cnt <= resp_cnt + 1;
      end
    end
  end

  // mod_start monitor: rising edges, high cycles, and rises after a too-short low run.
  int   rises = 0, hi_cnt = 0, gap_viol = 0, low_len = 100;
  logic prev_ms = 1'b0;
  always @(negedge clk) begin
    if (mod_start) begin
      hi_cnt++;
      if (!prev_ms) begin
        rises++;
        if (low_len < 2) gap_viol++;
      end
      low_len = 0;
    end else begin
      low_len++;
    end
    prev_ms = mod_start;
  end

  typedef struct {
    logic [31:0] b, e, m;
    logic [31:0] res;
    logic        err;
    int          ops;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input bit inject);
    int cyc, r0, h0, g0;
    logic [31:0] res_seen;
    resp_lat = v.lat;
    @(negedge clk);
    base = v.b; exponent = v.e; modulus = v.m; start = 1'b1;
    r0 = rises; h0 = hi_cnt; g0 = gap_viol;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
    cyc = 0;
    while (!done && cyc < 4000) begin
      if (inject && cyc == 5) begin
        base = 32'd3; exponent = 32'd7; modulus = 32'd11; start = 1'b1;
      end
      if (inject && cyc == 7) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, v.ops * (v.lat + 4) + 1);
    chk("result", result, v.res);
    chk("error", error, v.err);
    chk("busy_low_at_done", busy, 0);
    chk("mod_start_rises", rises - r0, v.ops);
    chk("mod_start_gap_viol", gap_viol - g0, 0);
    if (v.ops == 0) chk("mod_start_never_high", hi_cnt - h0, 0);
`ifdef MODEXP_OPCNT_EN
    chk("op_count", op_count, v.ops);
`endif
    res_seen = result;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("result_held", result, res_seen);
`ifdef MODEXP_OPCNT_EN
    chk("op_count_held", op_count, v.ops);
`endif
  endtask

  initial begin
    int n;
    //        b             e       m              res           err ops lat
    vecs[0] = '{32'd4,      32'd13, 32'd497,       32'd445,      0,  7,  3};
    vecs[1] = '{32'd2,      32'd10, 32'd1000,      32'd24,       0,  6,  3};
    vecs[2] = '{32'd5,      32'd0,  32'd7,         32'd1,        0,  0,  3};
    vecs[3] = '{32'd5,      32'd0,  32'd1,         32'd0,        0,  0,  3};
    vecs[4] = '{32'd9,      32'd3,  32'd0,         32'd0,        1,  0,  3};
    vecs[5] = '{32'd3,      32'd5,  32'd7,         32'd5,        0,  5,  1};
    vecs[6] = '{32'd10,     32'd1,  32'd3,         32'd1,        0,  2,  1};
    vecs[7] = '{32'd7,      32'd2,  32'd1,         32'd0,        0,  3,  2};
    vecs[8] = '{32'hFFFFFFFA, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFA, 0,  4,  2};

    rst = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mod_start", mod_start, 0);
    chk("rst_mod_dividend", mod_dividend, 0);
    chk("rst_mod_divisor", mod_divisor, 0);
`ifdef MODEXP_OPCNT_EN
    chk("rst_op_count", op_count, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

    // Second start during a run must not disturb the operands in flight.
    run_vec(vecs[0], 1'b1);

    // Reset while waiting on the remainder unit aborts at once.
    resp_lat = 3;
    @(negedge clk);
    base = 32'd4; exponent = 32'd13; modulus = 32'd497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!mod_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wait", mod_start, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_mod_start", mod_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", done, 0);
    run_vec(vecs[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

- Square-and-multiply modular exponentiation controller: computes result = base^exponent mod modulus for the RSA datapath.
- Acts as the initiator on the start/done modular-reduction handshake: it issues one double-width dividend at a time to an external remainder unit and consumes the remainder.
- Sits between the RSA work-distribution logic and the mod unit; it contains no divider of its own.

## Interface
- BITS, 32, operand width; modulus, base, exponent and remainder are BITS wide, products are 2*BITS wide.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- base  in  BITS  base operand, latched on accepted start
- exponent  in  BITS  exponent, latched on accepted start
- modulus  in  BITS  modulus, latched on accepted start
- result  out  BITS  final value; valid from done, held until next accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  modulus was 0; set with done, cleared on next accepted start
- mod_dividend  out  2*BITS  dividend to mod unit, stable while mod_start high
- mod_divisor  out  BITS  equals latched modulus
- mod_start  out  1  level request; held high until mod_done seen
- mod_done  in  1  mod unit remainder valid
- mod_remainder  in  BITS  mod unit result

## Operation
- States: IDLE, REQ, WAIT, GAP, NEXT, FINISH.
- On start in IDLE: latch base, exponent and modulus into b, e and m. Set acc = 1 and clear error.
  - m == 0: go to FINISH with result 0 and error 1.
  - e == 0: go to FINISH with result = (m == 1) ? 0 : 1; no mod request is issued.
  - Otherwise: issue op RED with dividend {0, b}.
- Request sequence: REQ drives mod_dividend and asserts mod_start, then WAIT.
- WAIT holds mod_start and mod_dividend until mod_done = 1. In that cycle, capture mod_remainder into the op's target and go to GAP.
- GAP drives mod_start = 0 for exactly one cycle, which clears the responder, then goes to NEXT.
- Ops and their targets:
  - RED: b = b mod m.
  - MUL: acc = acc*b mod m.
  - SQR: b = b*b mod m.
- NEXT sequencing, LSB first:
  - After RED, or after a SQR, evaluate e[0]. If 1, issue MUL; else shift e right by 1 and go to the SQR check.
  - After MUL, shift e right by 1.
  - SQR check: if e != 0, issue SQR; else go to FINISH.
- Products are full 2*BITS unsigned multiplies of two BITS-wide values; no truncation.
- FINISH: result = acc, done = 1 for one cycle, return to IDLE.
- start while busy is ignored, with no effect on latched operands.
- Reset values:
  - result 0, busy 0, done 0, error 0.
  - mod_start 0, mod_dividend 0, mod_divisor 0.
  - State IDLE.
- rst mid-operation aborts immediately. mod_start drops asynchronously, which also resets the mod unit; no done is produced.

## Timing
- Accepted start at edge N: busy = 1 from N+1.
- First mod_start high at N+2 (REQ registered).
- Each op costs REQ 1 + WAIT (L+1) + GAP 1 + NEXT 1 cycles, where L is the mod unit latency in cycles.
- mod_start rises at most once per op and never rises in the cycle immediately after it fell.
- done is asserted in the same cycle result updates. busy falls in the same cycle done is asserted.
- exponent == 0 or modulus == 0: done at N+2, mod_start never asserted.
- Op count for nonzero e with bit length k and popcount p: 1 RED + p MUL + (k−1) SQR.

## Configuration
- Macro MODEXP_OPCNT_EN.
- Defined: adds output port op_count (16 bits).
  - Cleared on accepted start.
  - Increments once per mod_done capture.
  - Holds its value after done.
  - Reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- base=4, exponent=13, modulus=497, with a behavioral mod responder at latency L=3 -> result=445, error=0, done exactly one cycle; op_count=7 when enabled.
- base=2, exponent=10, modulus=1000 -> result=24; op_count=6 when enabled; mod_start shows 6 rising edges, each separated by ≥1 low cycle.
- exponent=0 with (base=5, modulus=7) -> result=1; with modulus=1 -> result=0. In both cases done at N+2 and mod_start never high.
- modulus=0, base=9, exponent=3 -> result=0, error=1 at done; a following valid start clears error.
- Pulse start again mid-run of 4^13 mod 497 with different operands -> ignored, result=445.
- Assert rst during WAIT -> mod_start, busy and done go 0 immediately; a fresh start then gives a correct result.
